// File: rtl/add8u_err_pkg.sv
// Shared types and widths for the 8-bit approximate adder error scanner.
// Sweep space is every {b, a} operand pair, walked as a 16-bit count.
package add8u_err_pkg;

    localparam int OPW  = 8;
    localparam int SUMW = 9;
    localparam int CNTW = 17;
    localparam int ACCW = 25;
    localparam int KW   = 2 * OPW;
    localparam int DIFW = SUMW + 1;

    localparam int unsigned PAIRS = 65536;
    localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    // Stage-1 capture of one driven pair and the adder's answer
    typedef struct packed {
        logic            valid;
        logic            last;
        logic [OPW-1:0]  a;
        logic [OPW-1:0]  b;
        logic [SUMW-1:0] o;
        logic [SUMW-1:0] exact;
    } s1_t;

    // |o - exact| via a 10-bit two's complement difference
    function automatic logic [SUMW-1:0] abs_err(
        input logic [SUMW-1:0] o,
        input logic [SUMW-1:0] exact
    );
        logic [DIFW-1:0] d;
        logic [DIFW-1:0] m;
        d = {1'b0, o} - {1'b0, exact};
        m = d[DIFW-1] ? (~d + DIFW'(1)) : d;
        return m[SUMW-1:0];
    endfunction

endpackage

// File: rtl/add8u_err_acc.sv
// Stage 2 of the scanner: error magnitude, count, sum and worst case.
// The worst-case pair only moves on a strictly larger error.
module add8u_err_acc
    import add8u_err_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    input  logic [SUMW-1:0] o,
    input  logic [SUMW-1:0] exact,
    output logic [CNTW-1:0] err_cnt,
    output logic [ACCW-1:0] err_sum,
    output logic [SUMW-1:0] wce,
    output logic [OPW-1:0]  wce_a,
    output logic [OPW-1:0]  wce_b
);

    logic [SUMW-1:0] mag;

    // Magnitude of the captured pair's error
    always_comb begin
        mag = abs_err(o, exact);
    end

    // Accumulate statistics; clear wins over a valid sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            err_sum <= '0;
            wce     <= '0;
            wce_a   <= '0;
            wce_b   <= '0;
        end else if (clr) begin
            err_cnt <= '0;
            err_sum <= '0;
            wce     <= '0;
            wce_a   <= '0;
            wce_b   <= '0;
        end else if (in_valid) begin
            if (mag != '0) begin
                err_cnt <= err_cnt + 1'b1;
            end
            err_sum <= err_sum + ACCW'(mag);
            if (mag > wce) begin
                wce   <= mag;
                wce_a <= a;
                wce_b <= b;
            end
        end
    end

endmodule

// File: rtl/add8u_err_scanner.sv
// Exhaustive error scanner for an external 8-bit approximate adder.
// Drives every operand pair once and reports count, sum and worst error.
module add8u_err_scanner
    import add8u_err_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [OPW-1:0]  dut_a,
    output logic [OPW-1:0]  dut_b,
    input  logic [SUMW-1:0] dut_o,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] err_cnt,
    output logic [ACCW-1:0] err_sum,
    output logic [SUMW-1:0] wce,
    output logic [OPW-1:0]  wce_a,
    output logic [OPW-1:0]  wce_b
);

    state_t        state;
    logic [KW-1:0] k;
    s1_t           s1;
    logic          start_ok;

    // The counter register itself is the operand bus
    assign dut_a = k[OPW-1:0];
    assign dut_b = k[KW-1:OPW];

    // A start only counts when no sweep is in flight
    always_comb begin
        start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    end

    // Sweep control FSM with registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_SWEEP;
                        k     <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (k == K_LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (s1.valid && s1.last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the pair driven this cycle and its exact sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
        end else if (start_ok) begin
            s1.valid <= 1'b0;
            s1.last  <= 1'b0;
        end else begin
            s1.valid <= (state == S_SWEEP);
            s1.last  <= (k == K_LAST);
            s1.a     <= dut_a;
            s1.b     <= dut_b;
            s1.o     <= dut_o;
            s1.exact <= {1'b0, dut_a} + {1'b0, dut_b};
        end
    end

    add8u_err_acc u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .in_valid (s1.valid),
        .a        (s1.a),
        .b        (s1.b),
        .o        (s1.o),
        .exact    (s1.exact),
        .err_cnt  (err_cnt),
        .err_sum  (err_sum),
        .wce      (wce),
        .wce_a    (wce_a),
        .wce_b    (wce_b)
    );

endmodule

// File: tb/tb_add8u_err_scanner.sv
// Scoreboard bench for add8u_err_scanner with a behavioural adder model.
// Stimulus queues expected sweep results; a monitor checks them on done.
module tb_add8u_err_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  dut_a;
    logic [7:0]  dut_b;
    logic [8:0]  dut_o;
    logic        busy;
    logic        done;
    logic [16:0] err_cnt;
    logic [24:0] err_sum;
    logic [8:0]  wce;
    logic [7:0]  wce_a;
    logic [7:0]  wce_b;

    // 0 exact, 1 stuck at zero, 2 bit 0 forced high, 3 constant 511
    int mode = 0;

    typedef struct {
        int cnt;
        int sum;
        int wce;
        int wa;
        int wb;
        int edges;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errs = 0;
    int   cyc = 0;
    int   t_busy = 0;
    logic pb = 1'b0;
    logic pd = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        dut_o = {1'b0, dut_a} + {1'b0, dut_b};
        case (mode)
            1: dut_o = 9'd0;
            2: dut_o[0] = 1'b1;
            3: dut_o = 9'h1FF;
            default: ;
        endcase
    end

    add8u_err_scanner dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dut_a   (dut_a),
        .dut_b   (dut_b),
        .dut_o   (dut_o),
        .busy    (busy),
        .done    (done),
        .err_cnt (err_cnt),
        .err_sum (err_sum),
        .wce     (wce),
        .wce_a   (wce_a),
        .wce_b   (wce_b)
    );

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: time busy->done and pop one expectation per done rise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !pb) t_busy = cyc;
            if (done && !pd) begin
                if (q.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    e = q.pop_front();
                    cmp("sweep_edges", cyc - t_busy, e.edges);
                    cmp("final_err_cnt", int'(err_cnt), e.cnt);
                    cmp("final_err_sum", int'(err_sum), e.sum);
                    cmp("final_wce", int'(wce), e.wce);
                    cmp("final_wce_a", int'(wce_a), e.wa);
                    cmp("final_wce_b", int'(wce_b), e.wb);
                end
            end
            pb = busy;
            pd = done;
        end
    end

    // Start a sweep, stop at dut_a == m and check running results
    task automatic partial(input string tag, input int md, input int m,
                           input int c, input int s, input int w,
                           input int wa, input int wb);
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (int'(dut_a) != m && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            cmp({tag, "_timeout"}, int'(dut_a), m);
        end else begin
            cmp({tag, "_busy_done"}, int'({busy, done}), 2);
            cmp({tag, "_err_cnt"}, int'(err_cnt), c);
            cmp({tag, "_err_sum"}, int'(err_sum), s);
            cmp({tag, "_wce"}, int'(wce), w);
            cmp({tag, "_wce_a"}, int'(wce_a), wa);
            cmp({tag, "_wce_b"}, int'(wce_b), wb);
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        cmp("rst_operands", int'({dut_b, dut_a}), 0);
        cmp("rst_busy_done", int'({busy, done}), 0);
        cmp("rst_err_cnt", int'(err_cnt), 0);
        cmp("rst_err_sum", int'(err_sum), 0);
        cmp("rst_wce", int'({wce, wce_a, wce_b}), 0);
        rst = 1'b0;

        partial("stuck0", 1, 100, 98, 4851, 98, 98, 0);
        partial("lsb1", 2, 100, 50, 50, 1, 0, 0);
        partial("const511", 3, 10, 9, 4563, 511, 0, 0);
        partial("exact", 0, 50, 0, 0, 0, 0, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ({dut_b, dut_a} != 16'h1234 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        cmp("reach_1234", int'({dut_b, dut_a}), 32'h1234);
        cmp("pre_rst_err_cnt", int'(err_cnt), 32'h1232);
        #2 rst = 1'b1;
        #1;
        cmp("mid_rst_operands", int'({dut_b, dut_a}), 0);
        cmp("mid_rst_busy_done", int'({busy, done}), 0);
        cmp("mid_rst_err_cnt", int'(err_cnt), 0);
        cmp("mid_rst_err_sum", int'(err_sum), 0);
        cmp("mid_rst_wce", int'({wce, wce_a, wce_b}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        cmp("idle_after_rst", int'({busy, done, dut_a}), 0);

        e = '{cnt: 65535, sum: 16711680, wce: 510, wa: 255, wb: 255,
              edges: 65537};
        q.push_back(e);
        mode = 1;
        start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 70000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            cmp("sweep_timeout", int'(done), 1);
        end else begin
            @(negedge clk);
            cmp("restart_busy_done", int'({busy, done}), 2);
            cmp("restart_err_cnt", int'(err_cnt), 0);
            cmp("restart_err_sum", int'(err_sum), 0);
            cmp("restart_wce", int'({wce, wce_a, wce_b}), 0);
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("pending_expectations", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
